// File: rtl/perf_counter_ctrl_pkg.sv
// Shared encodings for the performance-counter controller: FSM states and
// the fixed slot assignment of the four event counters.
package perf_counter_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } state_t;

  localparam logic [1:0] IDX_TOTAL = 2'd0;
  localparam logic [1:0] IDX_JMP   = 2'd1;
  localparam logic [1:0] IDX_BR    = 2'd2;
  localparam logic [1:0] IDX_OTHER = 2'd3;

endpackage

// File: rtl/perf_counter_ctrl_sat.sv
// Saturating event counter with a sticky overflow flag; updates on the
// falling clock edge like the rest of the controller.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] q,
  output logic             ovf
);

  localparam logic [WIDTH-1:0] ONE = 1;

  // An increment at all-ones holds the value and latches the overflow flag.
  always_ff @(negedge clk) begin
    if (rst || clr) begin
      q   <= '0;
      ovf <= 1'b0;
    end else if (inc) begin
      if (q == '1) ovf <= 1'b1;
      else         q   <= q + ONE;
    end
  end

endmodule

// File: rtl/perf_counter_ctrl.sv
// CPU performance-counter controller: run/halt FSM, four saturating event
// counters and a manual or auto-scanned display select.
module perf_counter_ctrl
  import perf_counter_ctrl_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int SCAN_LOG2 = 4
) (
  input  logic             clk,
  input  logic             RST,
  input  logic             GO,
  input  logic             HALT,
  input  logic             CLR,
  input  logic             EV_JMP,
  input  logic             EV_BR,
  input  logic             AUTO,
  input  logic [1:0]       SEL,
  output logic [WIDTH-1:0] CNT_OUT,
  output logic [1:0]       CNT_IDX,
  output logic [1:0]       STATE,
  output logic [3:0]       OVF
);

  localparam logic [SCAN_LOG2-1:0] PRESC_ONE = 1;

  state_t               state;
  logic [SCAN_LOG2-1:0] presc;
  logic [1:0]           idx;
  logic [WIDTH-1:0]     cnt [4];
  logic [3:0]           ovf_v;
  logic [3:0]           inc;
  logic                 run_en;

  // Counting follows the registered state, so the cycle that sees HALT still counts.
  assign run_en = (state == RUN);

  always_comb begin
    inc            = '0;
    inc[IDX_TOTAL] = run_en;
    inc[IDX_JMP]   = run_en & EV_JMP;
    inc[IDX_BR]    = run_en & EV_BR;
    inc[IDX_OTHER] = run_en & ~EV_JMP & ~EV_BR;
  end

  for (genvar i = 0; i < 4; i++) begin : g_cnt
    sat_counter #(.WIDTH(WIDTH)) u_cnt (
      .clk (clk),
      .rst (RST),
      .clr (CLR),
      .inc (inc[i]),
      .q   (cnt[i]),
      .ovf (ovf_v[i])
    );
  end

  always_ff @(negedge clk) begin
    if (RST || CLR) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE:    if (GO) state <= RUN;
        RUN:     if (HALT) state <= HALTED;
                 else if (!GO) state <= IDLE;
        HALTED:  state <= HALTED;
        default: state <= IDLE;
      endcase
    end
  end

  // Scan/select runs in every state; CLR only restarts the prescaler.
  always_ff @(negedge clk) begin
    if (RST) begin
      presc <= '0;
      idx   <= '0;
    end else begin
      if (AUTO && !CLR) presc <= presc + PRESC_ONE;
      else              presc <= '0;
      if (!AUTO)                        idx <= SEL;
      else if (!CLR && (presc == '1))   idx <= idx + 2'd1;
    end
  end

  assign CNT_OUT = cnt[idx];
  assign CNT_IDX = idx;
  assign STATE   = state;
  assign OVF     = ovf_v;

endmodule

// File: tb/tb_perf_counter_ctrl.sv
// Scoreboard bench: stimulus queues expected outputs, a posedge monitor
// pops and compares them against the falling-edge DUT.
module tb_perf_counter_ctrl;

  localparam int WIDTH = 4;

  logic             clk = 1'b0;
  logic             RST = 1'b0, GO = 1'b0, HALT = 1'b0, CLR = 1'b0;
  logic             EV_JMP = 1'b0, EV_BR = 1'b0, AUTO = 1'b0;
  logic [1:0]       SEL = 2'd0;
  logic [WIDTH-1:0] CNT_OUT;
  logic [1:0]       CNT_IDX;
  logic [1:0]       STATE;
  logic [3:0]       OVF;

  typedef struct {
    int          kind;   // 0 CNT_OUT, 1 CNT_IDX, 2 STATE, 3 OVF
    string       name;
    logic [31:0] exp;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  perf_counter_ctrl #(.WIDTH(WIDTH), .SCAN_LOG2(2)) dut (
    .clk     (clk),
    .RST     (RST),
    .GO      (GO),
    .HALT    (HALT),
    .CLR     (CLR),
    .EV_JMP  (EV_JMP),
    .EV_BR   (EV_BR),
    .AUTO    (AUTO),
    .SEL     (SEL),
    .CNT_OUT (CNT_OUT),
    .CNT_IDX (CNT_IDX),
    .STATE   (STATE),
    .OVF     (OVF)
  );

  always #5 clk = ~clk;

  // Monitor: outputs are stable across the rising edge.
  always @(posedge clk) begin
    while (q.size() > 0) begin
      exp_t        e;
      logic [31:0] act;
      e = q.pop_front();
      case (e.kind)
        0:       act = 32'(CNT_OUT);
        1:       act = 32'(CNT_IDX);
        2:       act = 32'(STATE);
        default: act = 32'(OVF);
      endcase
      total++;
      if (act !== e.exp) begin
        bad++;
        $display("FAIL %s: got %0d expected %0d", e.name, act, e.exp);
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic expect_v(input int kind, input string name, input int val);
    exp_t e;
    e.kind = kind;
    e.name = name;
    e.exp  = 32'(val);
    q.push_back(e);
  endtask

  task automatic read_cnt(input int k, input int val, input string name);
    AUTO = 1'b0;
    SEL  = 2'(k);
    tick();
    expect_v(1, {name, "_idx"}, k);
    expect_v(0, name, val);
  endtask

  task automatic do_clr();
    CLR = 1'b1;
    tick();
    CLR = 1'b0;
  endtask

  // Enter RUN, then n counted cycles; GO drops on the last so it ends in IDLE.
  task automatic run_n(input int n, input logic jmp, input logic br);
    GO = 1'b1;
    tick();
    for (int i = 1; i <= n; i++) begin
      GO = (i < n);
      EV_JMP = jmp;
      EV_BR  = br;
      tick();
    end
    GO = 1'b0; EV_JMP = 1'b0; EV_BR = 1'b0;
  endtask

  initial begin
    // Reset
    RST = 1'b1;
    tick(); tick();
    RST = 1'b0;
    expect_v(2, "rst_state", 0);
    expect_v(3, "rst_ovf", 0);
    expect_v(1, "rst_idx", 0);
    expect_v(0, "rst_cnt", 0);

    // Basic run: 10 counted cycles, JMP on 2 and 5, BR on 7
    GO = 1'b1;
    tick();
    for (int i = 1; i <= 10; i++) begin
      GO     = (i < 10);
      EV_JMP = (i == 2 || i == 5);
      EV_BR  = (i == 7);
      tick();
    end
    GO = 1'b0; EV_JMP = 1'b0; EV_BR = 1'b0;
    expect_v(2, "run_state_idle", 0);
    read_cnt(0, 10, "run_c0");
    read_cnt(1, 2,  "run_c1");
    read_cnt(2, 1,  "run_c2");
    read_cnt(3, 7,  "run_c3");

    // Halt: one baseline cycle, the HALT+BR cycle counts, then frozen
    do_clr();
    GO = 1'b1;
    tick();
    tick();
    HALT = 1'b1; EV_BR = 1'b1;
    tick();
    HALT = 1'b0; EV_BR = 1'b0;
    expect_v(2, "halt_state", 2);
    EV_JMP = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    EV_JMP = 1'b0; GO = 1'b0;
    expect_v(2, "halt_state_hold", 2);
    read_cnt(0, 2, "halt_c0");
    read_cnt(1, 0, "halt_c1");
    read_cnt(2, 1, "halt_c2");
    read_cnt(3, 1, "halt_c3");
    expect_v(2, "halt_state_after_reads", 2);

    // Simultaneous JMP and BR
    do_clr();
    expect_v(2, "clr_state_idle", 0);
    run_n(3, 1'b1, 1'b1);
    read_cnt(0, 3, "both_c0");
    read_cnt(1, 3, "both_c1");
    read_cnt(2, 3, "both_c2");
    read_cnt(3, 0, "both_c3");

    // Auto-scan with prescaler of 4 (counters now 3,3,3,0)
    AUTO = 1'b0; SEL = 2'd0;
    tick();
    AUTO = 1'b1;
    expect_v(1, "scan_idx0", 0);
    tick(); tick(); tick();
    expect_v(1, "scan_idx0_hold", 0);
    tick();
    expect_v(1, "scan_idx1", 1);
    for (int i = 0; i < 4; i++) tick();
    expect_v(1, "scan_idx2", 2);
    expect_v(0, "scan_out2", 3);
    for (int i = 0; i < 4; i++) tick();
    expect_v(1, "scan_idx3", 3);
    expect_v(0, "scan_out3", 0);
    for (int i = 0; i < 4; i++) tick();
    expect_v(1, "scan_idx_wrap", 0);
    AUTO = 1'b0; SEL = 2'd2;
    expect_v(1, "sel_before_edge", 0);
    tick();
    expect_v(1, "sel_idx2", 2);
    expect_v(0, "sel_out_c2", 3);

    // Saturation at 15
    do_clr();
    run_n(20, 1'b0, 1'b0);
    expect_v(3, "sat_ovf", 4'b1001);
    read_cnt(0, 15, "sat_c0");
    read_cnt(1, 0,  "sat_c1");
    do_clr();
    expect_v(3, "sat_ovf_clr", 0);
    read_cnt(0, 0, "sat_c0_clr");

    // RST mid-RUN with nonzero counters and OVF set
    run_n(4, 1'b1, 1'b1);
    AUTO = 1'b0; SEL = 2'd1;
    GO = 1'b1;
    tick();
    for (int i = 0; i < 16; i++) tick();
    expect_v(2, "pre_rst_state", 1);
    expect_v(3, "pre_rst_ovf", 4'b1001);
    expect_v(0, "pre_rst_c1", 4);
    RST = 1'b1;
    tick();
    expect_v(2, "mid_rst_state", 0);
    expect_v(3, "mid_rst_ovf", 0);
    expect_v(1, "mid_rst_idx", 0);
    expect_v(0, "mid_rst_c0", 0);
    RST = 1'b0; GO = 1'b0;
    read_cnt(1, 0, "mid_rst_c1");
    read_cnt(2, 0, "mid_rst_c2");
    read_cnt(3, 0, "mid_rst_c3");

    tick(); tick();
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
